// File: rtl/pipe_ctrl_cc_if.sv
// pipe_ctrl_cc_if: bundle of pipeline-state inputs and stall/bubble/flag outputs
// exchanged between the Y86-64 pipeline datapath (master) and pipe_ctrl_cc (slave).
// With PIPE_PERF_CNT_EN defined the bundle also carries the performance counters.
interface pipe_ctrl_cc_if #(
    parameter int WIDTH = 64
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
);
    // Pipeline state observed by the controller
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [3:0]       E_destM;
    logic [WIDTH-1:0] e_opa;
    logic [WIDTH-1:0] e_opb;
    logic [WIDTH-1:0] e_res;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    // Controller results
    logic             e_cnd;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_cycles;
    logic [CNT_W-1:0] perf_retired;
    logic [CNT_W-1:0] perf_stalls;
    logic [CNT_W-1:0] perf_flushes;
`endif

    modport master (
`ifdef PIPE_PERF_CNT_EN
        input  perf_cycles, perf_retired, perf_stalls, perf_flushes,
`endif
        output D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_destM,
        output e_opa, e_opb, e_res, M_icode, m_stat, W_stat,
        input  e_cnd, cc_zf, cc_sf, cc_of,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted
    );

    modport slave (
`ifdef PIPE_PERF_CNT_EN
        output perf_cycles, perf_retired, perf_stalls, perf_flushes,
`endif
        input  D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_destM,
        input  e_opa, e_opb, e_res, M_icode, m_stat, W_stat,
        output e_cnd, cc_zf, cc_sf, cc_of,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted
    );
endinterface

// File: rtl/pipe_ctrl_cc.sv
// pipe_ctrl_cc: sequencing/control unit for the pipelined Y86-64 execute datapath.
// Owns the ZF/SF/OF condition-code register, evaluates the branch/cmov condition
// for the instruction in E, and drives the F/D/E/M/W stall and bubble controls
// (load/use, mispredict, ret, exceptions). A RUN/DRAIN/HALTED FSM lets the pipe
// drain after a non-AOK status and then freezes it until reset.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating performance counters.
module pipe_ctrl_cc #(
    parameter int         WIDTH = 64,
`ifdef PIPE_PERF_CNT_EN
    parameter int         CNT_W = 32,
`endif
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_cc_if.slave pif
);

    localparam logic [2:0] STAT_AOK  = 3'd1;

    localparam logic [3:0] IC_CMOV   = 4'h2;
    localparam logic [3:0] IC_MRMOV  = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    localparam logic [3:0] FN_ADD    = 4'h0;
    localparam logic [3:0] FN_SUB    = 4'h1;
    localparam logic [3:0] FN_XOR    = 4'h3;
    localparam logic [3:0] FN_AND    = 4'h4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Branch/cmov condition from the flags; unknown ifun never takes.
    function automatic logic f_cond(input logic [3:0] ifun, input logic zf,
                                    input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (ifun)
            4'h0:    f_cond = 1'b1;
            4'h1:    f_cond = lt | zf;
            4'h2:    f_cond = lt;
            4'h3:    f_cond = zf;
            4'h4:    f_cond = ~zf;
            4'h5:    f_cond = ~lt;
            4'h6:    f_cond = ~lt & ~zf;
            default: f_cond = 1'b0;
        endcase
    endfunction

    // Signed overflow from operand/result sign bits; logical ops never overflow.
    function automatic logic f_ovf(input logic [3:0] ifun, input logic sa,
                                   input logic sb, input logic sr);
        case (ifun)
            FN_ADD:  f_ovf = (sa == sb) && (sr != sa);
            FN_SUB:  f_ovf = (sa != sb) && (sr != sa);
            default: f_ovf = 1'b0;
        endcase
    endfunction

    state_e state_r;
    state_e state_s;
    logic   halted_r;

    logic   zf_r;
    logic   sf_r;
    logic   of_r;
    logic   cc_we_s;
    logic   zf_nx_s;
    logic   sf_nx_s;
    logic   of_nx_s;

    logic   e_cnd_s;
    logic   load_use_s;
    logic   mispred_s;
    logic   ret_in_s;

    logic   f_stall_s;
    logic   d_stall_s;
    logic   d_bubble_s;
    logic   e_bubble_s;
    logic   m_bubble_s;
    logic   w_stall_s;

    // Only the sign bits of the operands feed the overflow rule.
    logic   unused_opnd_s;
    assign unused_opnd_s = ^{pif.e_opa[WIDTH-2:0], pif.e_opb[WIDTH-2:0]};

    // Condition for the cmov/jXX in E, evaluated against the registered flags.
    always_comb begin
        e_cnd_s = 1'b0;
        if ((pif.E_icode == IC_CMOV) || (pif.E_icode == IC_JXX)) begin
            e_cnd_s = f_cond(pif.E_ifun, zf_r, sf_r, of_r);
        end else begin
            e_cnd_s = 1'b0;
        end
    end

    // Hazard detection: load/use on a memory read in E, mispredicted jump, ret in flight.
    always_comb begin
        load_use_s = ((pif.E_icode == IC_MRMOV) || (pif.E_icode == IC_POPQ)) &&
                     (pif.E_destM != RNONE) &&
                     ((pif.E_destM == pif.d_srcA) || (pif.E_destM == pif.d_srcB));
        mispred_s  = (pif.E_icode == IC_JXX) && !e_cnd_s;
        ret_in_s   = (pif.D_icode == IC_RET) || (pif.E_icode == IC_RET) ||
                     (pif.M_icode == IC_RET);
    end

    // Pipeline register controls; reset forces bubbles, HALTED freezes every stage.
    always_comb begin
        f_stall_s  = 1'b0;
        d_stall_s  = 1'b0;
        d_bubble_s = 1'b0;
        e_bubble_s = 1'b0;
        m_bubble_s = 1'b0;
        w_stall_s  = 1'b0;
        if (rst) begin
            d_bubble_s = 1'b1;
            e_bubble_s = 1'b1;
            m_bubble_s = 1'b1;
        end else if (state_r == ST_HALTED) begin
            f_stall_s  = 1'b1;
            d_stall_s  = 1'b1;
            w_stall_s  = 1'b1;
        end else begin
            f_stall_s  = load_use_s | ret_in_s;
            d_stall_s  = load_use_s;
            // A mispredict squashes D even with ret there; load/use keeps D stalled instead.
            d_bubble_s = mispred_s | (ret_in_s & !load_use_s);
            e_bubble_s = mispred_s | load_use_s;
            m_bubble_s = (pif.m_stat != STAT_AOK) | (pif.W_stat != STAT_AOK);
            w_stall_s  = (pif.W_stat != STAT_AOK);
        end
    end

    // Halt FSM next state: drain once M reports a fault, stop once it reaches W.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (pif.m_stat != STAT_AOK) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pif.W_stat != STAT_AOK) begin
                    state_s = ST_HALTED;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HALTED: state_s = ST_HALTED;
            default:   state_s = ST_HALTED;
        endcase
    end

    // Condition-code write enable and next flag values for an OPq in E.
    always_comb begin
        cc_we_s = (state_r == ST_RUN) && (pif.E_icode == IC_OPQ) &&
                  (pif.m_stat == STAT_AOK) && (pif.W_stat == STAT_AOK) &&
                  ((pif.E_ifun == FN_ADD) || (pif.E_ifun == FN_SUB) ||
                   (pif.E_ifun == FN_XOR) || (pif.E_ifun == FN_AND));
        zf_nx_s = (pif.e_res == {WIDTH{1'b0}});
        sf_nx_s = pif.e_res[WIDTH-1];
        of_nx_s = f_ovf(pif.E_ifun, pif.e_opa[WIDTH-1], pif.e_opb[WIDTH-1],
                        pif.e_res[WIDTH-1]);
    end

    // FSM state register and sticky halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            halted_r <= (state_s == ST_HALTED);
        end
    end

    // Architectural condition-code register; all three flags change together or not at all.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_r <= 1'b1;
            sf_r <= 1'b0;
            of_r <= 1'b0;
        end else if (cc_we_s) begin
            zf_r <= zf_nx_s;
            sf_r <= sf_nx_s;
            of_r <= of_nx_s;
        end else begin
            zf_r <= zf_r;
            sf_r <= sf_r;
            of_r <= of_r;
        end
    end

    assign pif.e_cnd    = e_cnd_s;
    assign pif.cc_zf    = zf_r;
    assign pif.cc_sf    = sf_r;
    assign pif.cc_of    = of_r;
    assign pif.F_stall  = f_stall_s;
    assign pif.D_stall  = d_stall_s;
    assign pif.D_bubble = d_bubble_s;
    assign pif.E_bubble = e_bubble_s;
    assign pif.M_bubble = m_bubble_s;
    assign pif.W_stall  = w_stall_s;
    assign pif.halted   = halted_r;

`ifdef PIPE_PERF_CNT_EN
    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            f_sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            f_sat_inc = v;
        end
    endfunction

    logic [CNT_W-1:0] cyc_r;
    logic [CNT_W-1:0] ret_r;
    logic [CNT_W-1:0] stl_r;
    logic [CNT_W-1:0] fls_r;
    logic             live_s;

    assign live_s = (state_r != ST_HALTED);

    // Performance counters; frozen once the pipe is halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r <= {CNT_W{1'b0}};
            ret_r <= {CNT_W{1'b0}};
            stl_r <= {CNT_W{1'b0}};
            fls_r <= {CNT_W{1'b0}};
        end else begin
            cyc_r <= f_sat_inc(cyc_r, live_s);
            ret_r <= f_sat_inc(ret_r, live_s && (pif.W_stat == STAT_AOK) && !w_stall_s);
            stl_r <= f_sat_inc(stl_r, live_s && f_stall_s);
            fls_r <= f_sat_inc(fls_r, live_s && mispred_s);
        end
    end

    assign pif.perf_cycles  = cyc_r;
    assign pif.perf_retired = ret_r;
    assign pif.perf_stalls  = stl_r;
    assign pif.perf_flushes = fls_r;
`endif

endmodule
